// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Drives the PLL reset, qualifies the PLL lock indication and only then
//   releases the system reset. Any loss of lock in RUN restarts the PLL. A
//   lock that never arrives causes timed retries, which are counted.
//
// Ports
//   refclk      : free-running reference clock (the PLL input, not an output)
//   rst         : synchronous active-high reset
//   locked      : PLL lock, asynchronous to refclk
//   pll_rst     : reset to the PLL, active-high
//   sys_rst     : system reset, active-high
//   ready       : high only in RUN
//   lock_lost   : one-cycle pulse when lock drops while in RUN
//   retry_count : saturating count of lock-timeout retries
module pll_reset_sequencer #(
  parameter int LOCK_SYNC_STAGES   = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 64,
  parameter int CNT_W              = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  // Terminal counts of the shared state counter.
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [LOCK_SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]                  retry_q, retry_d;
  logic                        pll_rst_q, pll_rst_d;
  logic                        sys_rst_q, sys_rst_d;
  logic                        ready_q, ready_d;
  logic                        lock_lost_q, lock_lost_d;
  logic                        locked_s;

  assign locked_s    = sync_q[LOCK_SYNC_STAGES-1];
  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;

  // Next state, counter, retry count and Moore outputs of the next state.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    sync_d      = {sync_q[LOCK_SYNC_STAGES-2:0], locked};

    case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_PLL_RESET;
        end
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still wins over the retry.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_PLL_RESET;
          if (retry_q != 8'hFF) begin
            retry_d = retry_q + 8'd1;
          end else begin
            retry_d = retry_q;
          end
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_STABLE;
        end
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d     = ST_PLL_RESET;
          lock_lost_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_PLL_RESET;
      end
    endcase

    // Every state change restarts the shared counter; RUN ignores it, so
    // wrapping there is harmless.
    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs are decoded from the next state so the registered copies
    // always agree with the state register.
    pll_rst_d = (state_d == ST_PLL_RESET);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  // State, counter, synchronizer and output registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_PLL_RESET;
      cnt_q       <= {CNT_W{1'b0}};
      sync_q      <= {LOCK_SYNC_STAGES{1'b0}};
      retry_q     <= 8'd0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer. A behavioural reference model predicts
// every output from the lock history; scenario tasks add timing checks.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int PRC  = 4;
  localparam int TO   = 20;
  localparam int STB  = 8;
  localparam int HLD  = 4;
  localparam int LOCK_TO_RUN = SYNC + 1 + STB + HLD;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, sys_rst, ready, lock_lost;
  logic [7:0] retry_count;

  logic       rst_sat    = 1'b1;
  logic       locked_sat = 1'b0;
  logic       pll_rst_sat, sys_rst_sat, ready_sat, lock_lost_sat;
  logic [7:0] retry_sat;

  logic [11:0] dut_obs;
  int vectors     = 0;
  int miscompares = 0;

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .LOCK_SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(TO),
    .LOCK_STABLE_CYCLES(STB), .RST_HOLD_CYCLES(HLD), .CNT_W(16)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready),
    .lock_lost(lock_lost), .retry_count(retry_count)
  );

  pll_reset_sequencer #(
    .LOCK_SYNC_STAGES(2), .PLL_RST_CYCLES(1), .LOCK_TIMEOUT(2),
    .LOCK_STABLE_CYCLES(8), .RST_HOLD_CYCLES(4), .CNT_W(16)
  ) dut_sat (
    .refclk(refclk), .rst(rst_sat), .locked(locked_sat),
    .pll_rst(pll_rst_sat), .sys_rst(sys_rst_sat), .ready(ready_sat),
    .lock_lost(lock_lost_sat), .retry_count(retry_sat)
  );

  assign dut_obs = {pll_rst, sys_rst, ready, lock_lost, retry_count};

  // Reference model: three phases (PLL reset pulse, qualifying, running).
  // While qualifying, 'idle' counts lock-less waiting cycles and 'streak'
  // counts consecutive high synchronized samples; RUN is reached once the
  // streak has covered the stable plus hold windows.
  localparam int M_PLL = 0, M_QUAL = 1, M_RUN = 2;
  int         m_mode = M_PLL;
  int         m_pll_left = PRC, m_idle = 0, m_streak = 0;
  logic       m_lost = 1'b0;
  logic [7:0] m_retry = 8'd0;
  logic [SYNC-1:0] m_sync = '0;

  task automatic model_step(input logic r, input logic l);
    logic ls;
    if (r) begin
      m_mode = M_PLL; m_pll_left = PRC; m_idle = 0; m_streak = 0;
      m_lost = 1'b0; m_retry = 8'd0; m_sync = '0;
    end else begin
      ls = m_sync[SYNC-1];
      m_lost = 1'b0;
      if (m_mode == M_PLL) begin
        m_pll_left = m_pll_left - 1;
        if (m_pll_left == 0) begin
          m_mode = M_QUAL; m_idle = 0; m_streak = 0;
        end
      end else if (m_mode == M_QUAL) begin
        if (m_streak == 0) begin
          if (ls) m_streak = 1;
          else if (m_idle == TO - 1) begin
            m_mode = M_PLL; m_pll_left = PRC;
            if (m_retry != 8'd255) m_retry = m_retry + 8'd1;
          end else m_idle = m_idle + 1;
        end else begin
          if (!ls) begin
            m_streak = 0; m_idle = 0;
          end else if (m_streak == STB + HLD) m_mode = M_RUN;
          else m_streak = m_streak + 1;
        end
      end else begin
        if (!ls) begin
          m_mode = M_PLL; m_pll_left = PRC; m_lost = 1'b1;
        end
      end
      m_sync = {m_sync[SYNC-2:0], l};
    end
  endtask

  function automatic logic [11:0] exp_vec();
    return {(m_mode == M_PLL), (m_mode != M_RUN), (m_mode == M_RUN), m_lost, m_retry};
  endfunction

  // One clock: the model consumes the inputs sampled at this edge, then
  // outputs are settled for comparison.
  task automatic tick();
    @(posedge refclk);
    model_step(rst, locked);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0;
    repeat (2) begin
      tick();
      vectors++;
      if (dut_obs !== 12'b1100_0000_0000) begin
        miscompares++; $display("FAIL reset_values: got %h expected %h", dut_obs, 12'b1100_0000_0000);
      end
      vectors++;
      if (dut_obs !== exp_vec()) begin
        miscompares++; $display("FAIL reset_model: got %h expected %h", dut_obs, exp_vec());
      end
    end
  endtask

  task automatic test_bringup();
    int n;
    rst = 1'b0; n = 0;
    do begin
      tick(); n++;
      vectors++;
      if (dut_obs !== exp_vec()) begin
        miscompares++; $display("FAIL bringup_model: got %h expected %h", dut_obs, exp_vec());
      end
    end while (pll_rst === 1'b1 && n < 50);
    vectors++;
    if (n !== PRC) begin
      miscompares++; $display("FAIL bringup_pll_len: got %0d expected %0d", n, PRC);
    end
    repeat (2) begin
      tick();
      vectors++;
      if (dut_obs !== exp_vec()) begin
        miscompares++; $display("FAIL bringup_model: got %h expected %h", dut_obs, exp_vec());
      end
    end
    locked = 1'b1; n = 0;
    do begin
      tick(); n++;
      vectors++;
      if (dut_obs !== exp_vec()) begin
        miscompares++; $display("FAIL bringup_model: got %h expected %h", dut_obs, exp_vec());
      end
    end while (sys_rst === 1'b1 && n < 100);
    vectors++;
    if (n !== LOCK_TO_RUN) begin
      miscompares++; $display("FAIL bringup_lock_to_run: got %0d expected %0d", n, LOCK_TO_RUN);
    end
    vectors++;
    if ({ready, retry_count} !== 9'h100) begin
      miscompares++; $display("FAIL bringup_ready: got %h expected %h", {ready, retry_count}, 9'h100);
    end
  endtask

  task automatic test_timeouts();
    int n;
    locked = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; n = 0;
    do begin
      tick(); n++;
      vectors++;
      if (dut_obs !== exp_vec()) begin
        miscompares++; $display("FAIL timeout_model: got %h expected %h", dut_obs, exp_vec());
      end
    end while (pll_rst === 1'b1 && n < 50);
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      do begin
        tick(); n++;
        vectors++;
        if (dut_obs !== exp_vec()) begin
          miscompares++; $display("FAIL timeout_model: got %h expected %h", dut_obs, exp_vec());
        end
      end while (pll_rst === 1'b0 && n < 100);
      vectors++;
      if (n !== TO) begin
        miscompares++; $display("FAIL timeout_wait_len: got %0d expected %0d", n, TO);
      end
      vectors++;
      if ({sys_rst, retry_count} !== {1'b1, 8'(k)}) begin
        miscompares++; $display("FAIL timeout_retry: got %h expected %h", {sys_rst, retry_count}, {1'b1, 8'(k)});
      end
      n = 0;
      do begin
        tick(); n++;
        vectors++;
        if (dut_obs !== exp_vec()) begin
          miscompares++; $display("FAIL timeout_model: got %h expected %h", dut_obs, exp_vec());
        end
      end while (pll_rst === 1'b1 && n < 50);
      vectors++;
      if (n !== PRC) begin
        miscompares++; $display("FAIL timeout_pll_len: got %0d expected %0d", n, PRC);
      end
    end
  endtask

  task automatic test_reset_hold();
    int n, h;
    locked = 1'b1;
    h = $urandom_range(14, 11);
    repeat (h) begin
      tick();
      vectors++;
      if (dut_obs !== exp_vec()) begin
        miscompares++; $display("FAIL rsthold_model: got %h expected %h", dut_obs, exp_vec());
      end
    end
    vectors++;
    if ({sys_rst, ready, retry_count} !== 10'h203) begin
      miscompares++; $display("FAIL rsthold_in_hold: got %h expected %h", {sys_rst, ready, retry_count}, 10'h203);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (dut_obs !== 12'b1100_0000_0000) begin
      miscompares++; $display("FAIL rsthold_reset: got %h expected %h", dut_obs, 12'b1100_0000_0000);
    end
    rst = 1'b0; n = 0;
    do begin
      tick(); n++;
      vectors++;
      if (dut_obs !== exp_vec()) begin
        miscompares++; $display("FAIL rsthold_model: got %h expected %h", dut_obs, exp_vec());
      end
    end while (pll_rst === 1'b1 && n < 50);
    vectors++;
    if (n !== PRC) begin
      miscompares++; $display("FAIL rsthold_pll_len: got %0d expected %0d", n, PRC);
    end
  endtask

  task automatic test_glitch_stable();
    int n, p, pll_hi;
    locked = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; n = 0;
    do begin
      tick(); n++;
    end while (pll_rst === 1'b1 && n < 50);
    locked = 1'b1; pll_hi = 0;
    p = $urandom_range(7, 4);
    repeat (p) begin
      tick();
      if (pll_rst === 1'b1 || lock_lost === 1'b1) pll_hi++;
    end
    locked = 1'b0;
    repeat (3) begin
      tick();
      if (pll_rst === 1'b1 || lock_lost === 1'b1) pll_hi++;
      vectors++;
      if (dut_obs !== exp_vec()) begin
        miscompares++; $display("FAIL glitch_model: got %h expected %h", dut_obs, exp_vec());
      end
    end
    locked = 1'b1; n = 0;
    do begin
      tick(); n++;
      if (pll_rst === 1'b1 || lock_lost === 1'b1) pll_hi++;
      vectors++;
      if (dut_obs !== exp_vec()) begin
        miscompares++; $display("FAIL glitch_model: got %h expected %h", dut_obs, exp_vec());
      end
    end while (sys_rst === 1'b1 && n < 100);
    vectors++;
    if (n !== LOCK_TO_RUN) begin
      miscompares++; $display("FAIL glitch_requal: got %0d expected %0d", n, LOCK_TO_RUN);
    end
    vectors++;
    if (pll_hi !== 0 || retry_count !== 8'd0) begin
      miscompares++; $display("FAIL glitch_no_retry: got pll_hi=%0d retry=%0d expected 0 0", pll_hi, retry_count);
    end
  endtask

  task automatic test_loss_run();
    int n, extra;
    repeat ($urandom_range(5, 0)) tick();
    locked = 1'b0; n = 0;
    do begin
      tick(); n++;
      vectors++;
      if (dut_obs !== exp_vec()) begin
        miscompares++; $display("FAIL loss_model: got %h expected %h", dut_obs, exp_vec());
      end
    end while (lock_lost !== 1'b1 && n < 50);
    vectors++;
    if (n !== SYNC + 1) begin
      miscompares++; $display("FAIL loss_latency: got %0d expected %0d", n, SYNC + 1);
    end
    vectors++;
    if ({pll_rst, sys_rst, ready} !== 3'b110) begin
      miscompares++; $display("FAIL loss_outputs: got %b expected %b", {pll_rst, sys_rst, ready}, 3'b110);
    end
    n = 0; extra = 0;
    do begin
      tick(); n++;
      if (lock_lost !== 1'b0) extra++;
    end while (pll_rst === 1'b1 && n < 50);
    vectors++;
    if (n !== PRC || extra !== 0) begin
      miscompares++; $display("FAIL loss_pulse: got pll_len=%0d extra_lost=%0d expected %0d 0", n, extra, PRC);
    end
    locked = 1'b1; n = 0;
    do begin
      tick(); n++;
      vectors++;
      if (dut_obs !== exp_vec()) begin
        miscompares++; $display("FAIL loss_model: got %h expected %h", dut_obs, exp_vec());
      end
    end while (sys_rst === 1'b1 && n < 100);
    vectors++;
    if (n !== LOCK_TO_RUN) begin
      miscompares++; $display("FAIL loss_relock: got %0d expected %0d", n, LOCK_TO_RUN);
    end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(24, 0) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      locked = ~locked;
      len = locked ? $urandom_range(40, 1) : $urandom_range(28, 1);
      repeat (len) begin
        tick();
        vectors++;
        if (dut_obs !== exp_vec()) begin
          miscompares++; $display("FAIL random_model: got %h expected %h", dut_obs, exp_vec());
        end
      end
    end
  endtask

  // With a 1-cycle PLL pulse and a 2-cycle timeout, a retry lands every
  // third cycle after reset release.
  task automatic test_saturation();
    logic [9:0] exp_s, got_s;
    int q;
    locked_sat = 1'b0; rst_sat = 1'b1;
    tick();
    rst_sat = 1'b0;
    for (int t = 1; t <= 910; t++) begin
      tick();
      q = (t / 3 > 255) ? 255 : t / 3;
      exp_s = {((t % 3) == 0), 1'b1, 8'(q)};
      got_s = {pll_rst_sat, sys_rst_sat, retry_sat};
      vectors++;
      if (got_s !== exp_s || ready_sat !== 1'b0 || lock_lost_sat !== 1'b0) begin
        miscompares++; $display("FAIL saturation_t%0d: got %h expected %h", t, got_s, exp_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_timeouts();
    test_reset_hold();
    test_glitch_stable();
    test_loss_run();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Lock monitor and reset sequencer that sits beside the system PLL wrapper on the free-running 50 MHz board clock. It drives the PLL's reset input, waits for and qualifies the PLL `locked` indication, and only then releases the system reset consumed by the Nios/SDRAM platform. Any loss of lock reasserts system reset and restarts the PLL. Lock timeouts trigger automatic retries, which are counted.

## Interface
Parameters:
- `LOCK_SYNC_STAGES`, 2: flops in the `locked` synchronizer; minimum 2.
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse; minimum 1.
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before a retry; 1 ms at 50 MHz.
- `LOCK_STABLE_CYCLES`, 1024: consecutive cycles synchronized `locked` must stay high before lock is accepted.
- `RST_HOLD_CYCLES`, 64: cycles `sys_rst` stays high after lock is accepted.
- `CNT_W`, 16: state counter width; must hold the largest cycle parameter minus 1.

Ports:
- `refclk`, input, 1: free-running reference clock (the PLL input clock, not a PLL output).
- `rst`, input, 1: reset, synchronous, active-high.
- `locked`, input, 1: PLL lock, asynchronous to `refclk`.
- `pll_rst`, output, 1: reset to the PLL `rst` input, active-high.
- `sys_rst`, output, 1: system reset, active-high.
- `ready`, output, 1: high only in RUN.
- `lock_lost`, output, 1: one-cycle pulse when lock drops while in RUN.
- `retry_count`, output, 8: number of lock-timeout retries; saturates at 255.

## Operation
- `locked` passes through a `LOCK_SYNC_STAGES` flop chain to produce `locked_s`. Only `locked_s` is used internally.
- One up-counter (`cnt`, `CNT_W` bits) is shared by all timed states. It clears on every state change.
- States and Moore outputs (`pll_rst`, `sys_rst`, `ready`):
  - PLL_RESET: 1, 1, 0. Exits to WAIT_LOCK when `cnt == PLL_RST_CYCLES-1`.
  - WAIT_LOCK: 0, 1, 0.
    - If `locked_s == 1`, go to STABLE.
    - Otherwise, when `cnt == LOCK_TIMEOUT-1`, go to PLL_RESET and increment `retry_count` (saturating).
    - If both conditions hold in the same cycle, the lock takes priority.
  - STABLE: 0, 1, 0.
    - If `locked_s == 0`, go to WAIT_LOCK. This is not a retry, and the timeout count restarts.
    - Otherwise, when `cnt == LOCK_STABLE_CYCLES-1`, go to HOLD.
  - HOLD: 0, 1, 0.
    - If `locked_s == 0`, go to WAIT_LOCK.
    - Otherwise, when `cnt == RST_HOLD_CYCLES-1`, go to RUN.
  - RUN: 0, 0, 1. If `locked_s == 0`, go to PLL_RESET and assert `lock_lost` for exactly one cycle.
- A drop of `locked_s` always takes priority over a counter expiry in the same cycle.
- `retry_count` clears only on `rst`. It does not clear on reaching RUN.

## Timing
- All outputs are registered and change only on the rising edge of `refclk`. Outputs are updated in the same edge as the state register, so they always match the current state.
- Reset values while `rst` is high: state PLL_RESET, `cnt=0`, `pll_rst=1`, `sys_rst=1`, `ready=0`, `lock_lost=0`, `retry_count=0`, synchronizer flops cleared to 0.
- Reset mid-operation takes effect at the next edge from any state.
- After `rst` falls, `pll_rst` stays high for exactly `PLL_RST_CYCLES` cycles.
- State occupancy:
  - PLL_RESET lasts exactly `PLL_RST_CYCLES` cycles.
  - A WAIT_LOCK that times out lasts exactly `LOCK_TIMEOUT` cycles.
  - A clean STABLE lasts `LOCK_STABLE_CYCLES` cycles, and a clean HOLD lasts `RST_HOLD_CYCLES` cycles.
- Latency from the first edge that samples `locked=1` to entering STABLE is `LOCK_SYNC_STAGES+1` edges.
- From the first edge sampling `locked=1` to the first cycle with `sys_rst=0` takes `LOCK_SYNC_STAGES+1+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES` cycles.
- Lock loss in RUN: `sys_rst` and `pll_rst` rise, and `ready` falls, `LOCK_SYNC_STAGES+1` edges after `locked` is first sampled low. `lock_lost` is high in that same first cycle only.
- A one-cycle glitch on `locked` shorter than the sampling window may be missed by the synchronizer. This is acceptable.

## Test plan
All scenarios use `PLL_RST_CYCLES=4`, `LOCK_TIMEOUT=20`, `LOCK_STABLE_CYCLES=8`, `RST_HOLD_CYCLES=4`, `LOCK_SYNC_STAGES=2`.
- Bring-up: `rst` high for 2 cycles; `locked` rises 3 cycles after `pll_rst` falls -> `pll_rst` high exactly 4 cycles after `rst` release; `sys_rst` falls and `ready` rises exactly 15 cycles after `locked` is first sampled high; `retry_count=0`.
- Timeout retries: `locked` held at 0 -> `pll_rst` pulses high for 4 cycles every 24 cycles; `retry_count` reads 1, 2, 3 after successive pulses; `sys_rst` stays 1.
- Glitch in STABLE: `locked` drops for 3 cycles midway through STABLE -> return to WAIT_LOCK; no `pll_rst` pulse; `retry_count` unchanged; full 8+4 qualification restarts after re-lock.
- Loss in RUN: drop `locked` -> `lock_lost` high for exactly 1 cycle; `sys_rst=1` and `ready=0` in that cycle; `pll_rst` high for 4 cycles; on re-lock, `sys_rst` falls 15 cycles later.
- Reset mid-HOLD: assert `rst` for 1 cycle -> next cycle `pll_rst=1`, `sys_rst=1`, `ready=0`, `retry_count=0`; the sequence restarts with a 4-cycle `pll_rst`.
- Saturation: `LOCK_TIMEOUT=2`, `PLL_RST_CYCLES=1`, `locked` held at 0 for 300 retries -> `retry_count` reaches 255 and holds; no wrap to 0.
